// File: rtl/button_autorepeat.sv
// rtl/button_autorepeat.sv - debounced push-button with press pulse and auto-repeat
// One instance per clock-setting button; output_pulse feeds an adjust counter.
module button_autorepeat #(
  parameter int SAMPLE_DIV     = 315_000,
  parameter int STABLE_SAMPLES = 3,
  parameter int HOLD_SAMPLES   = 80,
  parameter int REPEAT_SAMPLES = 20
) (
  input  logic video_clk,
  input  logic reset_n,
  input  logic button_in,
  output logic output_pulse,
  output logic pressed,
  output logic repeating
);

  localparam int DIV_W   = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int STAB_W  = (STABLE_SAMPLES > 2) ? $clog2(STABLE_SAMPLES) : 1;
  localparam int REP_MAX = (HOLD_SAMPLES > REPEAT_SAMPLES) ? HOLD_SAMPLES : REPEAT_SAMPLES;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_SAMPLES - 1);
  localparam logic [REP_W-1:0]  HOLD_N    = REP_W'(HOLD_SAMPLES);
  localparam logic [REP_W-1:0]  REPEAT_N  = REP_W'(REPEAT_SAMPLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  logic              sync0, sync1;
  logic [DIV_W-1:0]  div_cnt;
  logic [STAB_W-1:0] stab_cnt, stab_next;
  logic [REP_W-1:0]  rep_cnt, rep_next, rep_inc;
  logic [1:0]        state, state_next;
  logic              pressed_next, pulse_next, sample_edge;

  assign sample_edge = (div_cnt == DIV_LAST);
  assign rep_inc     = rep_cnt + 1'b1;

  always_comb begin
    pressed_next = pressed;
    stab_next    = stab_cnt;
    if (sync1 == pressed) begin
      stab_next = '0;
    end else if (stab_cnt == STAB_LAST) begin
      pressed_next = ~pressed;
      stab_next    = '0;
    end else begin
      stab_next = stab_cnt + 1'b1;
    end
  end

  // FSM sees the level that pressed takes on this same sample edge.
  always_comb begin
    state_next = state;
    rep_next   = rep_cnt;
    pulse_next = 1'b0;
    case (state)
      IDLE: begin
        if (pressed_next && !pressed) begin
          pulse_next = 1'b1;
          state_next = HOLD;
          rep_next   = '0;
        end
      end
      HOLD: begin
        if (!pressed_next) begin
          state_next = IDLE;
          rep_next   = '0;
        end else if (rep_inc == HOLD_N) begin
          pulse_next = 1'b1;
          state_next = REPEAT;
          rep_next   = '0;
        end else begin
          rep_next = rep_inc;
        end
      end
      REPEAT: begin
        // A release on a due-repeat edge suppresses that pulse.
        if (!pressed_next) begin
          state_next = IDLE;
          rep_next   = '0;
        end else if (rep_inc == REPEAT_N) begin
          pulse_next = 1'b1;
          rep_next   = '0;
        end else begin
          rep_next = rep_inc;
        end
      end
      default: begin
        state_next = IDLE;
        rep_next   = '0;
      end
    endcase
  end

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0        <= 1'b0;
      sync1        <= 1'b0;
      div_cnt      <= '0;
      stab_cnt     <= '0;
      rep_cnt      <= '0;
      state        <= IDLE;
      pressed      <= 1'b0;
      repeating    <= 1'b0;
      output_pulse <= 1'b0;
    end else begin
      sync0 <= button_in;
      sync1 <= sync0;
      if (sample_edge) begin
        div_cnt      <= '0;
        stab_cnt     <= stab_next;
        pressed      <= pressed_next;
        state        <= state_next;
        rep_cnt      <= rep_next;
        repeating    <= (state_next == REPEAT);
        output_pulse <= pulse_next;
      end else begin
        div_cnt      <= div_cnt + 1'b1;
        output_pulse <= 1'b0;
      end
    end
  end

endmodule
